// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle core.
//   WORD_W          : datapath word width
//   RSP_*           : memory responder FSM encoding
//   CU_*            : control-unit FSM encoding
//   mem_op_e        : operation latched by the memory responder
package mips_pkg;

    localparam int WORD_W = 32;

    // Memory responder state encoding.
    localparam logic [1:0] RSP_IDLE = 2'b00;
    localparam logic [1:0] RSP_WAIT = 2'b01;
    localparam logic [1:0] RSP_RESP = 2'b10;

    // Control-unit state encoding.
    localparam logic [3:0] CU_FETCH   = 4'd0;
    localparam logic [3:0] CU_DECODE  = 4'd1;
    localparam logic [3:0] CU_MEMADR  = 4'd2;
    localparam logic [3:0] CU_MEMRD   = 4'd3;
    localparam logic [3:0] CU_MEMWB   = 4'd4;
    localparam logic [3:0] CU_MEMWR   = 4'd5;
    localparam logic [3:0] CU_EXECUTE = 4'd6;
    localparam logic [3:0] CU_ALUWB   = 4'd7;
    localparam logic [3:0] CU_BRANCH  = 4'd8;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/mem_responder_if.sv
// Control-unit <-> memory responder bus.
//   MemRead, MemWrite : request strobes (master -> slave)
//   Addr, WriteData   : byte address and store data (master -> slave)
//   ReadData          : registered read result (slave -> master)
//   MemReady          : one-cycle completion pulse (slave -> master)
//   Busy              : request in flight (slave -> master)
//   MemErr            : misaligned-access flag, only with MEM_MISALIGN_TRAP_EN
interface mem_responder_if;
    import mips_pkg::*;

    logic              MemRead;
    logic              MemWrite;
    logic [WORD_W-1:0] Addr;
    logic [WORD_W-1:0] WriteData;
    logic [WORD_W-1:0] ReadData;
    logic              MemReady;
    logic              Busy;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              MemErr;

    modport master (output MemRead, MemWrite, Addr, WriteData,
                    input  ReadData, MemReady, Busy, MemErr);
    modport slave  (input  MemRead, MemWrite, Addr, WriteData,
                    output ReadData, MemReady, Busy, MemErr);
`else
    modport master (output MemRead, MemWrite, Addr, WriteData,
                    input  ReadData, MemReady, Busy);
    modport slave  (input  MemRead, MemWrite, Addr, WriteData,
                    output ReadData, MemReady, Busy);
`endif
endinterface

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, synchronous read.
//   cclk  : clock
//   rst   : async active-high reset, clears only the read register
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = load rdata from addr
//   addr  : word index
//   wdata : write data
//   rdata : read register, holds until the next enabled read
module mem_array
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              cclk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [1 << ADDR_W];

    // Storage is deliberately not reset.
    always_ff @(posedge cclk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for the multicycle control unit.
//   cclk : clock
//   rst  : async active-high reset
//   bus  : mem_responder_if.slave (MemRead/MemWrite/Addr/WriteData in,
//          ReadData/MemReady/Busy out, MemErr out with MEM_MISALIGN_TRAP_EN)
// Optional feature macro: MEM_MISALIGN_TRAP_EN (flag and suppress accesses
// with Addr[1:0] != 0 instead of truncating them to the word).
//
//   state | meaning
//   IDLE  | waiting for a strobe; request latched on the accepting edge
//   WAIT  | counting wait states down to 0
//   RESP  | array access on the next edge, MemReady follows for one cycle
module mem_responder
    import mips_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            cclk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx_q;
    logic [WORD_W-1:0] wdata_q;
    mem_op_e           op_q;
    logic              ready_q;
    logic              mem_en;
    logic [WORD_W-1:0] rdata;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    logic err_q;
    logic unused_addr;
    assign unused_addr = ^bus.Addr[WORD_W-1:ADDR_W+2];
`else
    logic unused_addr;
    assign unused_addr = ^{bus.Addr[WORD_W-1:ADDR_W+2], bus.Addr[1:0]};
`endif

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state   <= RSP_IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
            ready_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
            case (state)
                RSP_IDLE: begin
                    if (bus.MemRead || bus.MemWrite) begin
                        idx_q   <= bus.Addr[ADDR_W+1:2];
                        wdata_q <= bus.WriteData;
                        // Read wins a collision; the write is dropped.
                        op_q    <= bus.MemRead ? OP_READ : OP_WRITE;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_q <= |bus.Addr[1:0];
`endif
                        if (WAIT_CYCLES == 0) begin
                            state <= RSP_RESP;
                        end else begin
                            state <= RSP_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                RSP_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RSP_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RSP_RESP: begin
                    ready_q <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                    err_q   <= misalign_q;
`endif
                    state   <= RSP_IDLE;
                end
                default: state <= RSP_IDLE;
            endcase
        end
    end

    // The array is touched only on the RESP->IDLE edge, so a reset that
    // lands earlier leaves no partial write behind.
`ifdef MEM_MISALIGN_TRAP_EN
    assign mem_en = (state == RSP_RESP) && !misalign_q;
`else
    assign mem_en = (state == RSP_RESP);
`endif

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .cclk  (cclk),
        .rst   (rst),
        .en    (mem_en),
        .we    (op_q == OP_WRITE),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign bus.ReadData = rdata;
    assign bus.MemReady = ready_q;
    assign bus.Busy     = (state != RSP_IDLE);
`ifdef MEM_MISALIGN_TRAP_EN
    assign bus.MemErr   = err_q;
`endif

endmodule
